// File: rtl/conway_pkg.sv
// Shared types for the grid readout path: FSM state encoding and the row-index width helper.
package conway_pkg;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_SEND,
      RD_DONE
   } readout_state_t;

   // A single-row grid still needs a one-bit index port.
   function automatic int row_idx_w(input int height);
      return (height > 1) ? $clog2(height) : 1;
   endfunction

endpackage

// File: rtl/grid_row_select.sv
// Combinational row mux over the flattened grid; zero latency, no flow control.
module grid_row_select
   import conway_pkg::*;
#(
   parameter int GRID_WIDTH  = 5,
   parameter int GRID_HEIGHT = 5
) (
   input  logic [GRID_WIDTH*GRID_HEIGHT-1:0]   i_grid,
   input  logic [row_idx_w(GRID_HEIGHT)-1:0]   i_idx,
   output logic [GRID_WIDTH-1:0]               o_row
);

   always_comb begin
      o_row = '0;
      for (int r = 0; r < GRID_HEIGHT; r++) begin
         if (i_idx == row_idx_w(GRID_HEIGHT)'(r)) o_row = i_grid[r*GRID_WIDTH +: GRID_WIDTH];
      end
   end

endmodule

// File: rtl/grid_readout.sv
// Snapshots the grid on START and streams it one row per ROW_VALID/ROW_READY beat (first row 1 cycle after START, held under backpressure).
// Optional GRID_READOUT_PARITY_EN adds ROW_PARITY, the XOR of the presented row.
module grid_readout
   import conway_pkg::*;
#(
   parameter int GRID_WIDTH  = 5,
   parameter int GRID_HEIGHT = 5
) (
   input  logic                                CLK,
   input  logic                                RESET,
   input  logic [GRID_WIDTH*GRID_HEIGHT-1:0]   MEM_IN,
   input  logic                                START,
   input  logic                                ROW_READY,
   output logic [GRID_WIDTH-1:0]               ROW_DATA,
   output logic [row_idx_w(GRID_HEIGHT)-1:0]   ROW_INDEX,
   output logic                                ROW_VALID,
   output logic                                LAST_ROW,
   output logic                                BUSY,
   output logic                                DONE
`ifdef GRID_READOUT_PARITY_EN
   ,
   output logic                                ROW_PARITY
`endif
);

   localparam int                IDX_W    = row_idx_w(GRID_HEIGHT);
   localparam logic [IDX_W-1:0]  PRE_LAST = IDX_W'(GRID_HEIGHT - 2);

   readout_state_t                    r_state;
   logic [GRID_WIDTH*GRID_HEIGHT-1:0] r_snap;
   logic [IDX_W-1:0]                  r_row;
   logic                              r_valid;
   logic                              r_last;
   logic                              r_busy;
   logic                              r_done;
   logic [GRID_WIDTH-1:0]             w_row;

   grid_row_select #(
      .GRID_WIDTH  (GRID_WIDTH),
      .GRID_HEIGHT (GRID_HEIGHT)
   ) u_row_select (
      .i_grid (r_snap),
      .i_idx  (r_row),
      .o_row  (w_row)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= RD_IDLE;
         r_snap  <= '0;
         r_row   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            RD_IDLE: begin
               if (START) begin
                  r_snap  <= MEM_IN;
                  r_row   <= '0;
                  r_valid <= 1'b1;
                  r_last  <= (GRID_HEIGHT == 1);
                  r_busy  <= 1'b1;
                  r_state <= RD_SEND;
               end
            end
            RD_SEND: begin
               if (ROW_READY) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= RD_DONE;
                  end else begin
                     // LAST_ROW is registered, so it is decided one row ahead.
                     r_row  <= r_row + 1'b1;
                     r_last <= (r_row == PRE_LAST);
                  end
               end
            end
            RD_DONE: begin
               r_busy  <= 1'b0;
               r_state <= RD_IDLE;
            end
            default: r_state <= RD_IDLE;
         endcase
      end
   end

   assign ROW_DATA  = r_valid ? w_row : '0;
   assign ROW_INDEX = r_row;
   assign ROW_VALID = r_valid;
   assign LAST_ROW  = r_last;
   assign BUSY      = r_busy;
   assign DONE      = r_done;

`ifdef GRID_READOUT_PARITY_EN
   assign ROW_PARITY = ^ROW_DATA;
`endif

endmodule
